// File: rtl/clint_pkg.sv
// Shared definitions for the machine-timer interrupt path: FSM states, trap cause
// and the mtvec-based redirect computation.
package clint_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StEnter,
    StHandler
  } tic_state_t;

  localparam logic [63:0] MCAUSE_MTI          = 64'h8000_0000_0000_0007;
  localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;
  localparam logic [63:0] MTI_VEC_OFFSET      = 64'd28;

  // Vectored mode jumps to base + 4 * cause (7) for the machine timer interrupt.
  function automatic logic [63:0] mti_trap_target(input logic [63:0] mtvec);
    logic [63:0] base;
    base = mtvec & ~64'd3;
    if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
      return base + MTI_VEC_OFFSET;
    end
    return base;
  endfunction

endpackage

// File: rtl/timer_int_ctrl.sv
// Machine-timer interrupt controller: registers MTIP, gates it with MTIE/MIE and runs
// the trap-entry handshake with the core, blocking re-entry until mret.
module timer_int_ctrl
  import clint_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_timer_int_call,
  input  logic            i_mie_mtie,
  input  logic            i_mstatus_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic            i_instr_boundary,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic            i_trap_ack,
  input  logic            i_mret,
  output logic            o_mip_mtip,
  output logic            o_irq_req,
  output logic            o_trap_valid,
  output logic [XLEN-1:0] o_trap_pc,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mepc
);

  localparam logic [XLEN-1:0] McauseMti = {1'b1, MCAUSE_MTI[XLEN-2:0]};

  tic_state_t      state_q, state_d;
  logic            mtip_q;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            gate;

  assign gate = mtip_q & i_mie_mtie & i_mstatus_mie;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mtip_q    <= 1'b0;
      mepc_q    <= '0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      mtip_q    <= i_timer_int_call;
      mepc_q    <= mepc_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mepc_d    = mepc_q;
    trap_pc_d = trap_pc_q;
    unique case (state_q)
      StIdle: begin
        if (gate) state_d = StPending;
      end
      StPending: begin
        if (!gate) begin
          state_d = StIdle;
        end else if (i_instr_boundary) begin
          // Payload is frozen here so it stays stable for the whole ENTER handshake.
          state_d   = StEnter;
          mepc_d    = i_next_pc & ~XLEN'(3);
          trap_pc_d = XLEN'(mti_trap_target(64'(i_mtvec)));
        end
      end
      StEnter: begin
        if (i_trap_ack) state_d = StHandler;
      end
      StHandler: begin
        if (i_mret) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mip_mtip   = mtip_q;
    o_irq_req    = (state_q == StPending);
    o_trap_valid = (state_q == StEnter);
    o_mcause     = (state_q == StEnter) ? McauseMti : '0;
    o_mepc       = mepc_q;
    o_trap_pc    = trap_pc_q;
  end

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Self-checking bench for timer_int_ctrl: directed scenarios plus random traffic,
// compared every cycle against a behavioural model.
module tb_timer_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        call, mtie, mie, bnd, ack, mret;
  logic [63:0] mtvec, next_pc;
  logic        mip_mtip, irq_req, trap_valid;
  logic [63:0] trap_pc, mcause, mepc;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  // Model: phase 0 idle, 1 waiting for boundary, 2 trap offered, 3 in handler.
  int          m_phase;
  logic        m_mtip;
  logic [63:0] m_mepc, m_tpc;

  always #5 clk = ~clk;

  timer_int_ctrl #(.XLEN(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_timer_int_call (call),
    .i_mie_mtie       (mtie),
    .i_mstatus_mie    (mie),
    .i_mtvec          (mtvec),
    .i_instr_boundary (bnd),
    .i_next_pc        (next_pc),
    .i_trap_ack       (ack),
    .i_mret           (mret),
    .o_mip_mtip       (mip_mtip),
    .o_irq_req        (irq_req),
    .o_trap_valid     (trap_valid),
    .o_trap_pc        (trap_pc),
    .o_mcause         (mcause),
    .o_mepc           (mepc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_target(input logic [63:0] v);
    logic [63:0] base;
    base = v - (v % 4);
    return ((v % 4) == 1) ? base + 64'd28 : base;
  endfunction

  // Advance one clock with the currently driven inputs, update the model, compare.
  task automatic cyc();
    int          nph;
    logic        en;
    logic [63:0] nmepc, ntpc;
    en    = m_mtip && mtie && mie;
    nph   = m_phase;
    nmepc = m_mepc;
    ntpc  = m_tpc;
    case (m_phase)
      0: if (en) nph = 1;
      1: begin
        if (!en) nph = 0;
        else if (bnd) begin
          nph   = 2;
          nmepc = next_pc - (next_pc % 4);
          ntpc  = exp_target(mtvec);
        end
      end
      2: if (ack) nph = 3;
      default: if (mret) nph = 0;
    endcase
    @(posedge clk);
    #1;
    if (rst) begin
      m_phase = 0; m_mtip = 1'b0; m_mepc = '0; m_tpc = '0;
    end else begin
      m_phase = nph; m_mtip = call; m_mepc = nmepc; m_tpc = ntpc;
    end
    check_eq("mip_mtip", 64'(mip_mtip), 64'(m_mtip));
    check_eq("irq_req", 64'(irq_req), 64'(m_phase == 1));
    check_eq("trap_valid", 64'(trap_valid), 64'(m_phase == 2));
    check_eq("mcause", mcause, (m_phase == 2) ? 64'h8000_0000_0000_0007 : 64'd0);
    check_eq("mepc", mepc, m_mepc);
    check_eq("trap_pc", trap_pc, m_tpc);
  endtask

  task automatic idle_inputs();
    bnd = 1'b0; ack = 1'b0; mret = 1'b0; next_pc = '0;
  endtask

  logic [63:0] hold_pc, hold_mepc;

  initial begin
    rst = 1'b1; call = 1'b0; mtie = 1'b1; mie = 1'b1;
    mtvec = 64'h8000_0000; idle_inputs();
    m_phase = 0; m_mtip = 1'b0; m_mepc = '0; m_tpc = '0;
    cyc(); cyc();
    check_eq("reset_trap_valid", 64'(trap_valid), 64'd0);
    rst = 1'b0;
    cyc();

    // Direct mode, latency N+1/N+2/N+3/N+4.
    call = 1'b1; cyc();
    check_eq("lat_mip", 64'(mip_mtip), 64'd1);
    cyc();
    check_eq("lat_irq", 64'(irq_req), 64'd1);
    bnd = 1'b1; next_pc = 64'h1000; cyc(); idle_inputs();
    check_eq("s1_valid", 64'(trap_valid), 64'd1);
    check_eq("s1_pc", trap_pc, 64'h8000_0000);
    check_eq("s1_mepc", mepc, 64'h1000);
    check_eq("s1_mcause", mcause, 64'h8000_0000_0000_0007);
    ack = 1'b1; cyc(); ack = 1'b0;
    cyc(); cyc();
    check_eq("handler_no_irq", 64'(irq_req), 64'd0);
    mret = 1'b1; cyc(); mret = 1'b0;
    check_eq("mret_idle", 64'(irq_req), 64'd0);
    cyc();
    check_eq("after_mret_pend", 64'(irq_req), 64'd1);

    // Vectored mode, ack held off four cycles, misaligned next_pc.
    mtvec = 64'h8000_0001; bnd = 1'b1; next_pc = 64'h2003; cyc(); idle_inputs();
    hold_pc = trap_pc; hold_mepc = mepc;
    check_eq("s2_pc", trap_pc, 64'h8000_001C);
    check_eq("s2_mepc", mepc, 64'h2000);
    mtvec = 64'h1234_5671;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("hold_valid", 64'(trap_valid), 64'd1);
      check_eq("hold_pc", trap_pc, hold_pc);
      check_eq("hold_mepc", mepc, hold_mepc);
    end
    ack = 1'b1; cyc(); ack = 1'b0;
    check_eq("ack_drop", 64'(trap_valid), 64'd0);
    mret = 1'b1; cyc(); mret = 1'b0;
    cyc();

    // PENDING for 5 cycles then MIE drops; boundary arrives as gate falls.
    for (int i = 0; i < 5; i++) cyc();
    mie = 1'b0; bnd = 1'b1; cyc();
    check_eq("drop_irq", 64'(irq_req), 64'd0);
    cyc(); idle_inputs();
    check_eq("drop_no_trap", 64'(trap_valid), 64'd0);
    mie = 1'b1; cyc();

    // Wrap-around vectored target, then reset mid-ENTER.
    mtvec = 64'hFFFF_FFFF_FFFF_FFF5; bnd = 1'b1; next_pc = 64'h40; cyc(); idle_inputs();
    check_eq("wrap_pc", trap_pc, 64'h10);
    rst = 1'b1; cyc(); rst = 1'b0;
    check_eq("rst_valid", 64'(trap_valid), 64'd0);
    check_eq("rst_pc", trap_pc, 64'd0);
    mtie = 1'b0; bnd = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("dis_no_irq", 64'(irq_req), 64'd0);
    idle_inputs(); mtie = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) call = ~call;
      mtie    = ($urandom_range(0, 9) != 0);
      mie     = ($urandom_range(0, 9) != 0);
      bnd     = ($urandom_range(0, 3) == 0);
      ack     = ($urandom_range(0, 2) == 0);
      mret    = ($urandom_range(0, 5) == 0);
      mtvec   = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) mtvec[1:0] = 2'b01;
      next_pc = {$urandom, $urandom};
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_int_ctrl.md
# timer_int_ctrl

Machine-timer interrupt controller downstream of the CLINT timer block. It registers the CLINT's `mtime >= mtimecmp` level into `mip.MTIP` and gates it with `mie.MTIE` and `mstatus.MIE`. When the core reaches an instruction boundary, it runs the trap-entry handshake: it captures `mepc`, supplies `mcause` and the redirect target, then blocks re-entry until `mret`.

## Interface
- `XLEN`, 64, register and PC width.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_timer_int_call` input 1: level from the CLINT, `mtime >= mtimecmp`.
- `i_mie_mtie` input 1: `mie.MTIE` from the CSR file.
- `i_mstatus_mie` input 1: `mstatus.MIE` from the CSR file.
- `i_mtvec` input XLEN: `mtvec` CSR. Bits [1:0] are the mode; 01 means vectored.
- `i_instr_boundary` input 1: core can take a trap this cycle.
- `i_next_pc` input XLEN: PC of the next unexecuted instruction, valid with `i_instr_boundary`.
- `i_trap_ack` input 1: core accepted the redirect and updated the CSRs.
- `i_mret` input 1: single-cycle pulse, `mret` retiring.
- `o_mip_mtip` output 1: registered `mip.MTIP`.
- `o_irq_req` output 1: interrupt pending, waiting for a boundary.
- `o_trap_valid` output 1: trap-entry request to the core and CSR file.
- `o_trap_pc` output XLEN: redirect target.
- `o_mcause` output XLEN: cause value.
- `o_mepc` output XLEN: captured return PC.

## Operation
- `mtip_q <= i_timer_int_call` every cycle. `o_mip_mtip = mtip_q`; it is not gated by the enables.
- `gate = mtip_q & i_mie_mtie & i_mstatus_mie`, evaluated combinationally on current inputs.
- FSM states: IDLE, PENDING, ENTER, HANDLER.
  - IDLE: if `gate`, go to PENDING.
  - PENDING:
    - `!gate` → IDLE; no trap is taken (covers a `mtimecmp` rewrite or MIE cleared).
    - `gate & i_instr_boundary` → ENTER, with `mepc_q <= {i_next_pc[XLEN-1:2], 2'b00}`.
    - Otherwise stay.
  - ENTER: hold `o_trap_valid` and all of its payload stable until `i_trap_ack`, then go to HANDLER. The gate is not re-checked; the trap is committed.
  - HANDLER: on `i_mret` → IDLE. The CSR file cleared MIE on entry; a still-high `mtip_q` re-triggers only after `mret` restores MIE.
- `i_mret` outside HANDLER is ignored. `i_trap_ack` outside ENTER is ignored.
- Output decoding:
  - `o_irq_req = (state == PENDING)`.
  - `o_trap_valid = (state == ENTER)`.
- Payload:
  - `o_mcause = MCAUSE_MTI`, i.e. bit XLEN-1 set and the low bits equal to 7. The value is constant but is driven 0 outside ENTER.
  - `o_mepc = mepc_q`.
  - Base = `{i_mtvec[XLEN-1:2], 2'b00}`. `o_trap_pc` = base + 28 when mode is 01, otherwise base. Arithmetic is XLEN-wide and wraps.
  - `o_trap_pc` is registered at PENDING→ENTER so it stays stable during ENTER.

## Timing
- Reset values: state IDLE, `mtip_q` 0, `mepc_q` 0, trap-PC register 0. All outputs are 0.
- A reset in any state returns to IDLE next cycle with no trap outputs, including mid-ENTER.
- Latency from `i_timer_int_call` rising in cycle N, with both enables high:
  - `o_mip_mtip` high in N+1.
  - `o_irq_req` high in N+2.
  - With a boundary in N+2, `o_trap_valid` is high in N+3.
  - With ack in N+3, the FSM is in HANDLER in N+4.
- Boundary and gate drop in the same cycle: no capture, go to IDLE.
- `i_mret` and `gate` in the same cycle in HANDLER: go to IDLE first. PENDING comes one cycle later at the earliest.
- `o_trap_valid` may last any number of cycles. It deasserts the cycle after ack.

## Structure
- Shared package `clint_pkg` holds:
  - the state enum `tic_state_t`;
  - `MCAUSE_MTI`;
  - `MTVEC_MODE_VECTORED = 2'b01`;
  - `MTI_VEC_OFFSET = 28`.
- Single module, no sub-module. The target computation is a small inline function in the package.

## Test plan
- `i_timer_int_call` rises at N, enables high, `mtvec = 0x8000_0000`, boundary at N+2 with `i_next_pc = 0x1000` → `o_trap_valid` at N+3 with `o_trap_pc = 0x8000_0000`, `o_mepc = 0x1000`, `o_mcause = 0x8000_0000_0000_0007`.
- `mtvec = 0x8000_0001`, otherwise as the first scenario → `o_trap_pc = 0x8000_001C`.
- PENDING for 5 cycles, then `i_mstatus_mie` drops with no boundary → `o_irq_req` falls the next cycle, `o_trap_valid` is never asserted, state is IDLE.
- Ack held off 4 cycles → `o_trap_valid` and payload stable for all 4 cycles. Then `mtip_q` is held high in HANDLER with no `o_irq_req` until `i_mret`. The next PENDING follows `mret`.
- `rst` asserted during ENTER → all outputs 0 next cycle. A later boundary with the enables low produces no trap.
